// File: rtl/counter_request_arbiter_if.sv
// Purpose : pulse-line inputs and counter-grant outputs of counter_request_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: none; grants are one-cycle strobes and the consumer must take them.
// Ports   : PLS_P/PLS_M pulse lines, SLOT service strobe, GOJAM restart clear (master -> slave);
//           CTR_REQ, CTR_VLD, CTR_ADDR, PINC, MINC, LOSTCNT (slave -> master).
interface counter_request_arbiter_if #(
  parameter int NCH    = 8,
  parameter int ADDR_W = 12
);
  logic [NCH-1:0]    PLS_P;
  logic [NCH-1:0]    PLS_M;
  logic              SLOT;
  logic              GOJAM;
  logic              CTR_REQ;
  logic              CTR_VLD;
  logic [ADDR_W-1:0] CTR_ADDR;
  logic              PINC;
  logic              MINC;
  logic [7:0]        LOSTCNT;

  // master: the pulse source / slot sequencer side
  modport master (
    output PLS_P, PLS_M, SLOT, GOJAM,
    input  CTR_REQ, CTR_VLD, CTR_ADDR, PINC, MINC, LOSTCNT
  );

  // slave: the arbiter itself
  modport slave (
    input  PLS_P, PLS_M, SLOT, GOJAM,
    output CTR_REQ, CTR_VLD, CTR_ADDR, PINC, MINC, LOSTCNT
  );
endinterface

// File: rtl/counter_request_arbiter.sv
// Purpose : edge-detects CDU/optics/PIPA plus/minus pulse lines, holds one pending request per
//           counter and grants the lowest-index request per SLOT as address + PINC/MINC strobe.
// Latency : grant 1 cycle after SLOT; CTR_REQ 1 cycle after the pending update.
// Backpressure: none; a pulse arriving while the same-polarity request is pending is dropped and
//           counted in LOSTCNT (saturating).
// Ports   : CLOCK, rst (sync, active-high); io_bus (slave modport) carries the pulse lines,
//           SLOT, GOJAM and the registered grant outputs.
module counter_request_arbiter #(
  parameter int                NCH       = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'o0032
) (
  input  logic                        CLOCK,
  input  logic                        rst,
  counter_request_arbiter_if.slave    io_bus
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(NCH + 1);

  logic [NCH-1:0]    r_prev_p, r_prev_m;
  logic [NCH-1:0]    r_pend_p, r_pend_m;
  logic              r_req, r_vld, r_pinc, r_minc;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_lost;

  logic [NCH-1:0]    w_edge_p, w_edge_m;
  logic [NCH-1:0]    w_nxt_p, w_nxt_m;
  logic              w_pend_any;
  logic              w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic [CNT_W-1:0]  w_drops;
  logic [8:0]        w_lost_sum;
  logic [7:0]        w_lost_nxt;

  assign w_edge_p   = io_bus.PLS_P & ~r_prev_p;
  assign w_edge_m   = io_bus.PLS_M & ~r_prev_m;
  assign w_pend_any = |(r_pend_p | r_pend_m);
  // GOJAM suppresses any grant in its cycle
  assign w_grant    = io_bus.SLOT & w_pend_any & ~io_bus.GOJAM;

  // Fixed priority: lowest index wins, so scan downward and let the last hit stand.
  always_comb begin
    w_gidx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pend_p[i] | r_pend_m[i]) begin
        w_gidx = IDX_W'(i);
      end
    end
  end

  // Pending update. The grant clear comes first, so an edge colliding with its own channel's
  // grant sees an empty slot and simply becomes the next request (no cancel, no loss).
  always_comb begin
    w_nxt_p = r_pend_p;
    w_nxt_m = r_pend_m;
    w_drops = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant && (w_gidx == IDX_W'(i))) begin
        w_nxt_p[i] = 1'b0;
        w_nxt_m[i] = 1'b0;
      end
      if (w_edge_p[i] && !w_edge_m[i]) begin
        if (w_nxt_m[i]) begin
          w_nxt_m[i] = 1'b0;            // opposite request cancels: net zero
        end else if (w_nxt_p[i]) begin
          w_drops = w_drops + CNT_W'(1);
        end else begin
          w_nxt_p[i] = 1'b1;
        end
      end else if (w_edge_m[i] && !w_edge_p[i]) begin
        if (w_nxt_p[i]) begin
          w_nxt_p[i] = 1'b0;
        end else if (w_nxt_m[i]) begin
          w_drops = w_drops + CNT_W'(1);
        end else begin
          w_nxt_m[i] = 1'b1;
        end
      end
    end
  end

  // Several channels may drop in the same cycle; add them all, then saturate.
  assign w_lost_sum = 9'(r_lost) + 9'(w_drops);
  assign w_lost_nxt = w_lost_sum[8] ? 8'hFF : w_lost_sum[7:0];

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_prev_p <= '0;
      r_prev_m <= '0;
      r_pend_p <= '0;
      r_pend_m <= '0;
      r_req    <= 1'b0;
      r_vld    <= 1'b0;
      r_addr   <= '0;
      r_pinc   <= 1'b0;
      r_minc   <= 1'b0;
      r_lost   <= '0;
    end else begin
      r_prev_p <= io_bus.PLS_P;
      r_prev_m <= io_bus.PLS_M;
      if (io_bus.GOJAM) begin
        // edges of this cycle are discarded; loss count is kept across restart
        r_pend_p <= '0;
        r_pend_m <= '0;
        r_req    <= 1'b0;
        r_vld    <= 1'b0;
        r_pinc   <= 1'b0;
        r_minc   <= 1'b0;
      end else begin
        r_pend_p <= w_nxt_p;
        r_pend_m <= w_nxt_m;
        r_req    <= |(w_nxt_p | w_nxt_m);
        r_lost   <= w_lost_nxt;
        r_vld    <= w_grant;
        r_pinc   <= w_grant & r_pend_p[w_gidx];
        r_minc   <= w_grant & r_pend_m[w_gidx];
        if (w_grant) begin
          r_addr <= BASE_ADDR + ADDR_W'(w_gidx);   // wraps modulo 2^ADDR_W
        end
      end
    end
  end

  assign io_bus.CTR_REQ  = r_req;
  assign io_bus.CTR_VLD  = r_vld;
  assign io_bus.CTR_ADDR = r_addr;
  assign io_bus.PINC     = r_pinc;
  assign io_bus.MINC     = r_minc;
  assign io_bus.LOSTCNT  = r_lost;

endmodule
